// File: rtl/led_status_pkg.sv
// Shared types and constants for the front-panel status LED arbiter and frame timer.
package led_status_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ERROR   = 2'd2
    } arb_state_e;

    localparam logic [1:0] LED_CODE_ONE   = 2'd0;
    localparam logic [1:0] LED_CODE_TWO   = 2'd1;
    localparam logic [1:0] LED_CODE_THREE = 2'd2;
    localparam logic [1:0] LED_CODE_ERR   = 2'd3;

    localparam int LED_FRAME_STEPS = 16;
    localparam int LED_FRAME_W     = $clog2(LED_FRAME_STEPS);

    // Index/counter width that never collapses to zero bits.
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_frame_timer.sv
// Blink-step prescaler and 16-step frame counter; pulses frame_start_o on the
// last clock of each frame so consumers stay aligned with the LED indicator.
module led_frame_timer
    import led_status_pkg::*;
#(
    parameter int CNTR_WIDTH = 3,
    parameter int CNTR_TICK  = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic frame_start_o
);

    logic [CNTR_WIDTH-1:0]  tick_cntr_q, tick_cntr_d;
    logic [LED_FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   tick;

    assign tick = (tick_cntr_q == CNTR_WIDTH'(CNTR_TICK - 1));

    always_comb begin
        tick_cntr_d = tick ? '0 : tick_cntr_q + 1'b1;
        frame_cnt_d = tick ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tick_cntr_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            tick_cntr_q <= tick_cntr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_start_o = tick && (frame_cnt_q == LED_FRAME_W'(LED_FRAME_STEPS - 1));

endmodule

// File: rtl/led_status_arbiter.sv
// Frame-aligned fixed-priority arbiter for the single status LED, with minimum
// display hold. Optional sticky error display enabled by LED_ARB_ERR_LATCH_EN.
module led_status_arbiter
    import led_status_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int CNTR_WIDTH = 3,
    parameter int CNTR_TICK  = 4,
    parameter int MIN_FRAMES = 2
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   code,
    input  logic                   err_in,
    input  logic                   err_clr,
    output logic [1:0]             state,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   frame_start
);

    localparam int IDX_W  = safe_clog2(NUM_REQ);
    localparam int HOLD_W = safe_clog2(MIN_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(MIN_FRAMES - 1);

    arb_state_e         fsm_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   idx_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [1:0]         state_q;

    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [1:0]         win_code;
    logic [1:0]         gnt_code;
    logic               gnt_req_hi;

    led_frame_timer #(
        .CNTR_WIDTH (CNTR_WIDTH),
        .CNTR_TICK  (CNTR_TICK)
    ) u_frame_timer (
        .clk_i         (Clk),
        .rst_ni        (Rst_n),
        .frame_start_o (frame_start)
    );

`ifdef LED_ARB_ERR_LATCH_EN
    logic err_q;

    // A set on the same edge as a clear wins, so a persistent fault stays visible.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            err_q <= 1'b0;
        end else if (err_in) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_err;
    assign unused_err = err_in ^ err_clr;
`endif

    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_oh   = '0;
        win_code = LED_CODE_ONE;
        gnt_code = LED_CODE_ONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !win_vld) begin
                win_vld   = 1'b1;
                win_idx   = IDX_W'(i);
                win_oh[i] = 1'b1;
                win_code  = code[2*i +: 2];
            end
            if (idx_q == IDX_W'(i)) begin
                gnt_code = code[2*i +: 2];
            end
        end
    end

    assign gnt_req_hi = |(req & grant_q);

    // Everything moves on frame_start only, so a blink pattern is never cut short.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            fsm_q   <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            state_q <= LED_CODE_ONE;
        end else if (frame_start) begin
`ifdef LED_ARB_ERR_LATCH_EN
            if (err_q) begin
                fsm_q   <= ST_ERROR;
                grant_q <= '0;
                hold_q  <= '0;
                state_q <= LED_CODE_ERR;
            end else
`endif
            if (fsm_q == ST_GRANTED && gnt_req_hi && hold_q != '0) begin
                hold_q  <= hold_q - 1'b1;
                state_q <= gnt_code;
            end else if (fsm_q == ST_GRANTED && gnt_req_hi && win_idx == idx_q) begin
                state_q <= gnt_code;
            end else if (win_vld) begin
                fsm_q   <= ST_GRANTED;
                grant_q <= win_oh;
                idx_q   <= win_idx;
                hold_q  <= HOLD_RELOAD;
                state_q <= win_code;
            end else begin
                fsm_q   <= ST_IDLE;
                grant_q <= '0;
                hold_q  <= '0;
                state_q <= LED_CODE_ONE;
            end
        end
    end

    assign state = state_q;
    assign grant = grant_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed plus randomized bench for led_status_arbiter against a frame-level
// reference model; error expectations follow LED_ARB_ERR_LATCH_EN.
module tb_led_status_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int CNTR_WIDTH = 3;
    localparam int CNTR_TICK  = 4;
    localparam int MIN_FRAMES = 2;
    localparam int FRAME      = 16 * CNTR_TICK;
`ifdef LED_ARB_ERR_LATCH_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                 Clk = 1'b0;
    logic                 Rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] code;
    logic                 err_in;
    logic                 err_clr;
    logic [1:0]           state;
    logic [NUM_REQ-1:0]   grant;
    logic                 frame_start;

    always #5 Clk = ~Clk;

    led_status_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .CNTR_WIDTH (CNTR_WIDTH),
        .CNTR_TICK  (CNTR_TICK),
        .MIN_FRAMES (MIN_FRAMES)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .req         (req),
        .code        (code),
        .err_in      (err_in),
        .err_clr     (err_clr),
        .state       (state),
        .grant       (grant),
        .frame_start (frame_start)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycle index since reset release, granted requester,
    // frames shown since grant, sticky error flag and error display.
    int       m_cyc;
    int       m_gidx;
    int       m_shown;
    bit       m_err;
    bit       m_err_disp;
    logic [1:0] m_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, m_cyc, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] exp_grant();
        return (m_gidx >= 0) ? NUM_REQ'(1 << m_gidx) : '0;
    endfunction

    function automatic logic [1:0] exp_state();
        if (m_err_disp) return 2'd3;
        return (m_gidx >= 0) ? m_code : 2'd0;
    endfunction

    task automatic model_edge();
        int win;
        if (!Rst_n) begin
            m_cyc = 0; m_gidx = -1; m_shown = 0;
            m_err = 1'b0; m_err_disp = 1'b0; m_code = 2'd0;
        end else begin
            if ((m_cyc % FRAME) == FRAME - 1) begin
                if (ERR_EN && m_err) begin
                    m_err_disp = 1'b1; m_gidx = -1; m_shown = 0;
                end else begin
                    win = -1;
                    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) win = i;
                    m_err_disp = 1'b0;
                    if (m_gidx >= 0 && req[m_gidx]) begin
                        m_shown++;
                        if (m_shown >= MIN_FRAMES && win != m_gidx) begin
                            m_gidx = win; m_shown = 0;
                        end
                    end else begin
                        m_gidx = win; m_shown = 0;
                    end
                    m_code = 2'd0;
                    for (int i = 0; i < NUM_REQ; i++) if (i == m_gidx) m_code = code[2*i +: 2];
                end
            end
            if (err_in) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_cyc++;
        end
    endtask

    task automatic tick_cyc();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        chk("frame_start", {31'd0, frame_start}, {31'd0, (m_cyc % FRAME) == FRAME - 1});
        chk("grant", 32'(grant), 32'(exp_grant()));
        chk("state", 32'(state), 32'(exp_state()));
    endtask

    task automatic run_to(input int c);
        int n = 0;
        while (m_cyc < c && n < 4000) begin
            tick_cyc();
            n++;
        end
    endtask

    initial begin
        Rst_n = 1'b0; req = '0; code = '0; err_in = 1'b0; err_clr = 1'b0;
        m_cyc = 0; m_gidx = -1; m_shown = 0; m_err = 1'b0; m_err_disp = 1'b0; m_code = 2'd0;
        @(negedge Clk);
        repeat (5) tick_cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        Rst_n = 1'b1;

        run_to(10);  req[2] = 1'b1; code[5:4] = 2'd1;
        run_to(63);  chk("fs_63", {31'd0, frame_start}, 32'd1);
                     chk("grant_pre64", 32'(grant), 32'd0);
        run_to(64);  chk("grant_64", 32'(grant), 32'b0100);
                     chk("state_64", 32'(state), 32'd1);
        run_to(70);  req[0] = 1'b1; code[1:0] = 2'd2;
        run_to(127); chk("fs_127", {31'd0, frame_start}, 32'd1);
        run_to(191); chk("hold_191", 32'(grant), 32'b0100);
        run_to(192); chk("preempt_grant", 32'(grant), 32'b0001);
                     chk("preempt_state", 32'(state), 32'd2);
        run_to(200); req[0] = 1'b0;
        run_to(256); chk("drop_regrant", 32'(grant), 32'b0100);
        run_to(260); req[2] = 1'b0;
        run_to(320); chk("drop_idle_grant", 32'(grant), 32'd0);
                     chk("drop_idle_state", 32'(state), 32'd0);

        run_to(330); err_in = 1'b1; tick_cyc(); err_in = 1'b0;
        run_to(340); req[1] = 1'b1; code[3:2] = 2'd2;
        run_to(384); chk("err_state", 32'(state), ERR_EN ? 32'd3 : 32'd2);
                     chk("err_grant", 32'(grant), ERR_EN ? 32'd0 : 32'b0010);
        run_to(400); err_in = 1'b1; err_clr = 1'b1; tick_cyc(); err_in = 1'b0; err_clr = 1'b0;
        run_to(448); chk("err_both_state", 32'(state), ERR_EN ? 32'd3 : 32'd2);
        run_to(450); err_clr = 1'b1; tick_cyc(); err_clr = 1'b0;
        run_to(512); chk("resume_state", 32'(state), 32'd2);
                     chk("resume_grant", 32'(grant), 32'b0010);

        run_to(550); Rst_n = 1'b0; tick_cyc();
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        Rst_n = 1'b1;
        run_to(63);  chk("midrst_fs", {31'd0, frame_start}, 32'd1);
        run_to(64);  chk("midrst_regrant", 32'(grant), 32'b0010);

        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 39) == 0) req = req ^ NUM_REQ'(1 << $urandom_range(0, NUM_REQ - 1));
            if ($urandom_range(0, 19) == 0) code = (2*NUM_REQ)'($urandom);
            err_in  = ($urandom_range(0, 399) == 0);
            err_clr = ($urandom_range(0, 199) == 0);
            Rst_n   = ($urandom_range(0, 2499) != 0);
            tick_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
